// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op/state encodings and the conditional-negate helper shared by the HI/LO unit.
package muldiv_pkg;
    localparam int MAX_W = 64;
    typedef enum logic [1:0] {OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11} op_e;
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;
    // Callers widen to MAX_W and cast back; low bits of -x are width-independent.
    function automatic logic [MAX_W-1:0] cneg(input logic [MAX_W-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction
endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: execute-stage request/result bundle for the HI/LO unit.
interface muldiv_unit_if import muldiv_pkg::*; #(parameter int WIDTH = 32);
    logic             start;
    logic             flush;
    op_e              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    modport master(output start, flush, op, a, b, input busy, done, hi, lo);
    modport slave(input start, flush, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_div_core.sv
// muldiv_div_core: unsigned restoring divider, one quotient bit per enabled cycle.
module muldiv_div_core import muldiv_pkg::*; #(parameter int WIDTH = 32) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quo_o,
    output logic [WIDTH-1:0] rem_o
);
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [WIDTH:0]   trial, diff;
    // quo_q doubles as the dividend shifter: its MSB feeds the remainder, quotient bits enter at the LSB.
    assign trial = {rem_q, quo_q[WIDTH-1]};
    assign diff  = trial - {1'b0, dvs_q};
    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        if (load_i) begin
            rem_d = '0;
            quo_d = dividend_i;
            dvs_d = divisor_i;
        end else if (en_i) begin
            rem_d = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
        end
    end
    assign quo_o = quo_q;
    assign rem_o = rem_q;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU HI/LO unit with busy stall and done pulse.
// Define MULDIV_FAST_MUL_EN to compute multiplies with one registered full-width product.
module muldiv_unit import muldiv_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic           clk,
    input  logic           rst,
    muldiv_unit_if.slave   bus
);
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d, hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               neg_q, neg_d, rneg_q, rneg_d, div_q, div_d, done_q, done_d;
    logic               sg, is_div, a_neg, b_neg, dz, accept, last;
    logic [WIDTH-1:0]   a_mag, b_mag, quo, rem, quo_fix, rem_fix;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH:0]     sum;
    assign sg       = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign is_div   = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    assign a_neg    = sg & bus.a[WIDTH-1];
    assign b_neg    = sg & bus.b[WIDTH-1];
    assign a_mag    = WIDTH'(cneg(MAX_W'(bus.a), a_neg));
    assign b_mag    = WIDTH'(cneg(MAX_W'(bus.b), b_neg));
    assign dz       = bus.b == '0;
    assign accept   = bus.start && !bus.flush && state_q == IDLE;
    assign last     = cnt_q == CNT_W'(WIDTH - 1);
    assign sum      = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    assign prod_fix = (2*WIDTH)'(cneg(MAX_W'(prod_q), neg_q));
    assign quo_fix  = WIDTH'(cneg(MAX_W'(quo), neg_q));
    assign rem_fix  = WIDTH'(cneg(MAX_W'(rem), rneg_q));
`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] full_prod;
    assign full_prod = {{WIDTH{a_neg}}, bus.a} * {{WIDTH{b_neg}}, bus.b};
`endif
    muldiv_div_core #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst       (rst),
        .load_i    (accept && is_div && !dz),
        .en_i      (state_q == DIV && !bus.flush),
        .dividend_i(a_mag),
        .divisor_i (b_mag),
        .quo_o     (quo),
        .rem_o     (rem)
    );
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        div_d   = div_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (accept) begin
                cnt_d   = '0;
                mcand_d = a_mag;
                prod_d  = {{WIDTH{1'b0}}, b_mag};
                neg_d   = a_neg ^ b_neg;
                rneg_d  = a_neg;
                div_d   = is_div;
                // Divide by zero skips iteration: result is staged in prod_q as {a, all-ones}.
                if (is_div && dz) begin
                    state_d = FIX;
                    div_d   = 1'b0;
                    neg_d   = 1'b0;
                    prod_d  = {bus.a, {WIDTH{1'b1}}};
                end else if (is_div) state_d = DIV;
`ifdef MULDIV_FAST_MUL_EN
                else begin
                    state_d = FIX;
                    neg_d   = 1'b0;
                    prod_d  = full_prod;
                end
`else
                else state_d = MUL;
`endif
            end
        end else if (bus.flush) state_d = IDLE;
        else if (state_q == FIX) begin
            state_d      = IDLE;
            done_d       = 1'b1;
            {hi_d, lo_d} = div_q ? {rem_fix, quo_fix} : prod_fix;
        end else begin
            cnt_d = cnt_q + 1'b1;
            if (state_q == MUL) prod_d = {sum, prod_q[WIDTH-1:1]};
            if (last) state_d = FIX;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            div_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            div_q   <= div_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end
    assign bus.busy = state_q != IDLE;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule
